// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Runs MUL, UMULH, UDIV or SDIV in XLEN steps and writes the result back through the register file port.
module ex_muldiv_unit #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   write_data,
    output logic [REG_AW-1:0] write_reg,
    output logic              reg_write_enable
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     counter;
    logic [1:0]        op_q;
    logic [REG_AW-1:0] dest_q;
    logic              neg_q;
    logic              div_zero_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              accept;
    logic              finish;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [XLEN-1:0]   result;

    assign busy             = (state != S_IDLE);
    assign reg_write_enable = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush outranks both a new request and completion.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    next_state = S_CALC;
                    accept     = 1'b1;
                end
            end
            S_CALC: begin
                if (flush) begin
                    next_state = S_IDLE;
                end else if (counter == CW'(1)) begin
                    next_state = S_FIX;
                end
            end
            S_FIX: begin
                next_state = S_IDLE;
                finish     = !flush;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // hi_q/lo_q hold the product halves for multiply, and remainder/quotient for divide.
    always_comb begin
        abs_a     = operand_a[XLEN-1] ? -operand_a : operand_a;
        abs_b     = operand_b[XLEN-1] ? -operand_b : operand_b;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[1]) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        case (op_q)
            OP_MUL:   result = lo_q;
            OP_UMULH: result = hi_q;
            default:  result = div_zero_q ? '0 : (neg_q ? -lo_q : lo_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done       <= 1'b0;
            write_data <= '0;
            write_reg  <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                counter    <= CW'(XLEN);
                op_q       <= op;
                dest_q     <= dest_reg;
                neg_q      <= (op == OP_SDIV) && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                div_zero_q <= (operand_b == '0);
                hi_q       <= '0;
                if (op[1]) begin
                    opnd_q <= (op == OP_SDIV) ? abs_b : operand_b;
                    lo_q   <= (op == OP_SDIV) ? abs_a : operand_a;
                end else begin
                    opnd_q <= operand_a;
                    lo_q   <= operand_b;
                end
            end else if (state == S_CALC && !flush) begin
                counter <= counter - CW'(1);
                hi_q    <= step_hi;
                lo_q    <= step_lo;
            end
            if (finish) begin
                write_data <= result;
                write_reg  <= dest_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: arithmetic results, latency, busy/start interplay, flush and reset.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] operand_a = '0;
    logic [63:0] operand_b = '0;
    logic [4:0]  dest_reg = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write_enable;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    int lat;
    int done_snap;

    ex_muldiv_unit #(.XLEN(64), .REG_AW(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .op               (op),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .dest_reg         (dest_reg),
        .flush            (flush),
        .busy             (busy),
        .done             (done),
        .write_data       (write_data),
        .write_reg        (write_reg),
        .reg_write_enable (reg_write_enable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the operand bus afterwards and counts cycles until DONE.
    task automatic applyStimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] d, output int latency);
        op = o;
        operand_a = a;
        operand_b = b;
        dest_reg = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        operand_a = 64'hDEAD_BEEF_1234_5678;
        operand_b = 64'h0BAD_F00D_8765_4321;
        latency = 0;
        do begin
            tick();
            latency++;
        end while (!done && latency < 200);
    endtask

    initial begin
        tick();
        tick();
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_wdata", write_data, 64'd0);
        checkOutput("reset_wreg", {59'd0, write_reg}, 64'd0);
        checkOutput("reset_rwe", {63'd0, reg_write_enable}, 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of a divide.
        op = 2'b10; operand_a = 64'd100; operand_b = 64'd7; dest_reg = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checkOutput("calc_busy", {63'd0, busy}, 64'd1);
        done_snap = done_count;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("async_rst_done", {63'd0, done}, 64'd0);
        #1 rst_n = 1'b1;
        repeat (80) tick();
        checkOutput("rst_no_done", 64'(done_count - done_snap), 64'd0);

        applyStimulus(2'b00, 64'd5, 64'hFFFF, 5'd3, lat);
        checkOutput("mul_latency", 64'(lat), 64'd65);
        checkOutput("mul_data", write_data, 64'h4FFFB);
        checkOutput("mul_reg", {59'd0, write_reg}, 64'd3);
        checkOutput("mul_rwe", {63'd0, reg_write_enable}, 64'd1);
        checkOutput("mul_busy_at_done", {63'd0, busy}, 64'd0);
        tick();
        checkOutput("mul_done_pulse", {63'd0, done}, 64'd0);
        checkOutput("mul_rwe_pulse", {63'd0, reg_write_enable}, 64'd0);
        checkOutput("mul_data_hold", write_data, 64'h4FFFB);

        applyStimulus(2'b01, '1, '1, 5'd10, lat);
        checkOutput("umulh_data", write_data, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("umulh_reg", {59'd0, write_reg}, 64'd10);
        applyStimulus(2'b00, '1, '1, 5'd11, lat);
        checkOutput("mul_ones_data", write_data, 64'h1);

        applyStimulus(2'b11, -64'sd7, 64'd2, 5'd12, lat);
        checkOutput("sdiv_neg_data", write_data, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("sdiv_neg_latency", 64'(lat), 64'd65);
        applyStimulus(2'b11, 64'h8000_0000_0000_0000, '1, 5'd13, lat);
        checkOutput("sdiv_ovf_data", write_data, 64'h8000_0000_0000_0000);
        applyStimulus(2'b11, -64'sd100, -64'sd7, 5'd14, lat);
        checkOutput("sdiv_both_neg", write_data, 64'd14);
        applyStimulus(2'b10, 64'd5, 64'd0, 5'd15, lat);
        checkOutput("udiv_zero_data", write_data, 64'd0);
        checkOutput("udiv_zero_latency", 64'(lat), 64'd65);
        applyStimulus(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd16, lat);
        checkOutput("udiv_big_data", write_data, 64'h0FFF_FFFF_FFFF_FFFF);

        // A second request while busy must be ignored.
        op = 2'b10; operand_a = 64'd100; operand_b = 64'd7; dest_reg = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        op = 2'b00; operand_a = 64'd3; operand_b = 64'd3; dest_reg = 5'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_start_busy", {63'd0, busy}, 64'd1);
        lat = 10;
        do begin
            tick();
            lat++;
        end while (!done && lat < 200);
        checkOutput("busy_start_latency", 64'(lat), 64'd65);
        checkOutput("busy_start_data", write_data, 64'd14);
        checkOutput("busy_start_reg", {59'd0, write_reg}, 64'd5);

        // DONE is high now; a request issued this cycle is accepted.
        applyStimulus(2'b00, 64'd6, 64'd7, 5'd7, lat);
        checkOutput("b2b_latency", 64'(lat), 64'd65);
        checkOutput("b2b_data", write_data, 64'd42);
        checkOutput("b2b_reg", {59'd0, write_reg}, 64'd7);

        // Flush mid-divide at the 30th edge after acceptance.
        op = 2'b10; operand_a = 64'd1000; operand_b = 64'd3; dest_reg = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        done_snap = done_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_busy", {63'd0, busy}, 64'd0);
        repeat (70) tick();
        checkOutput("flush_no_done", 64'(done_count - done_snap), 64'd0);
        checkOutput("flush_data_hold", write_data, 64'd42);
        checkOutput("flush_reg_hold", {59'd0, write_reg}, 64'd7);
        applyStimulus(2'b10, 64'd1000, 64'd3, 5'd2, lat);
        checkOutput("post_flush_latency", 64'(lat), 64'd65);
        checkOutput("post_flush_data", write_data, 64'd333);

        // Flush with start while idle drops the request.
        tick();
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        checkOutput("idle_flush_start", {63'd0, busy}, 64'd0);
        checkOutput("idle_flush_data", write_data, 64'd333);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
